// File: rtl/uart_rx_if.sv
// rtl/uart_rx_if.sv - received-byte valid/ready port between uart_rx and its consumer
interface uart_rx_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;

  modport master (
    output rx_data,
    output rx_valid,
    input  rx_ready
  );

  modport slave (
    input  rx_data,
    input  rx_valid,
    output rx_ready
  );
endinterface

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver with majority-voted mid-bit sampling
module uart_rx #(
  parameter int CLKS_PER_BIT = 87
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      rx_in,
  uart_rx_if.master rx,
  output logic      frame_err,
  output logic      overrun,
  output logic      busy
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_t;

  state_t        state;
  logic          rx_meta;
  logic          rx_s;
  logic [2:0]    hist;
  logic          bit_val;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;

  assign bit_val = (hist[0] & hist[1]) | (hist[0] & hist[2]) | (hist[1] & hist[2]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      hist    <= 3'b111;
    end else begin
      rx_meta <= rx_in;
      rx_s    <= rx_meta;
      hist    <= {hist[1:0], rx_s};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      bit_idx     <= '0;
      shift       <= '0;
      rx.rx_data  <= '0;
      rx.rx_valid <= 1'b0;
      frame_err   <= 1'b0;
      overrun     <= 1'b0;
      busy        <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      if (rx.rx_valid && rx.rx_ready) begin
        rx.rx_valid <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (!rx_s) begin
            state <= START;
            cnt   <= '0;
            busy  <= 1'b1;
          end
        end
        START: begin
          if (cnt == HALF) begin
            cnt <= '0;
            if (bit_val) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              state   <= DATA;
              bit_idx <= '0;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (cnt == LAST) begin
            cnt     <= '0;
            shift   <= {bit_val, shift[7:1]};
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) begin
              state <= STOP;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STOP: begin
          if (cnt == LAST) begin
            cnt <= '0;
            if (bit_val) begin
              state <= IDLE;
              busy  <= 1'b0;
              // A byte accepted on this same edge frees the slot for the new one.
              if (!rx.rx_valid || rx.rx_ready) begin
                rx.rx_data  <= shift;
                rx.rx_valid <= 1'b1;
              end else begin
                overrun <= 1'b1;
              end
            end else begin
              frame_err <= 1'b1;
              state     <= BRK;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        BRK: begin
          // Hold here until the line idles so a stuck-low line is not read as 0x00 frames.
          if (rx_s) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - directed self-checking bench for uart_rx at 16 clocks per bit
module tb_uart_rx;
  localparam int CPB = 16;

  logic clk;
  logic rst_n;
  logic rx_in;
  logic frame_err;
  logic overrun;
  logic busy;

  uart_rx_if rx_if ();

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx_in     (rx_in),
    .rx        (rx_if),
    .frame_err (frame_err),
    .overrun   (overrun),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  int         valid_cycles = 0;
  int         fe_count     = 0;
  int         ov_count     = 0;
  logic [7:0] last_data    = 8'h00;

  always @(negedge clk) begin
    if (rst_n) begin
      if (rx_if.rx_valid) begin
        valid_cycles = valid_cycles + 1;
        last_data    = rx_if.rx_data;
      end
      if (frame_err) fe_count = fe_count + 1;
      if (overrun)   ov_count = ov_count + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int cycles);
    rx_in = 1'b1;
    repeat (cycles) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] data, input logic stop_bit, input int glitch_bit,
                            input logic ready_pulse, output logic busy_mid);
    busy_mid = 1'b0;
    rx_in = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_in = data[i];
      if (i == glitch_bit) begin
        repeat (CPB / 2) @(negedge clk);
        rx_in = 1'b1;
        @(negedge clk);
        rx_in = data[i];
        repeat (CPB / 2 - 1) @(negedge clk);
      end else begin
        repeat (CPB) @(negedge clk);
      end
      if (i == 4) busy_mid = busy;
    end
    rx_in = stop_bit;
    if (ready_pulse) begin
      repeat (11) @(negedge clk);
      rx_if.rx_ready = 1'b1;
      @(negedge clk);
      rx_if.rx_ready = 1'b0;
      repeat (CPB - 12) @(negedge clk);
    end else begin
      repeat (CPB) @(negedge clk);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not reach the summary");
    $fatal(1, "timeout");
  end

  initial begin
    int   vc0;
    int   fe0;
    int   ov0;
    logic bm;

    rst_n = 1'b0;
    rx_in = 1'b1;
    rx_if.rx_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_rx_valid", 32'(rx_if.rx_valid), 0);
    chk("reset_rx_data", 32'(rx_if.rx_data), 0);
    chk("reset_busy", 32'(busy), 0);
    chk("reset_frame_err", 32'(frame_err), 0);
    chk("reset_overrun", 32'(overrun), 0);
    rst_n = 1'b1;
    idle(5);

    // Nominal 0xA5 with rx_ready held high.
    vc0 = valid_cycles; fe0 = fe_count; ov0 = ov_count;
    send_frame(8'hA5, 1'b1, -1, 1'b0, bm);
    idle(20);
    chk("a5_busy_mid", 32'(bm), 1);
    chk("a5_data", 32'(last_data), 32'h A5);
    chk("a5_valid_cycles", 32'(valid_cycles - vc0), 1);
    chk("a5_frame_err", 32'(fe_count - fe0), 0);
    chk("a5_overrun", 32'(ov_count - ov0), 0);
    chk("a5_busy_idle", 32'(busy), 0);

    // Four-cycle low pulse is a false start.
    vc0 = valid_cycles; fe0 = fe_count;
    rx_in = 1'b0;
    repeat (4) @(negedge clk);
    idle(40);
    chk("false_start_valid", 32'(valid_cycles - vc0), 0);
    chk("false_start_fe", 32'(fe_count - fe0), 0);
    chk("false_start_busy", 32'(busy), 0);

    // One-cycle high glitch mid-way through data bit 3 of 0x00.
    vc0 = valid_cycles;
    last_data = 8'hFF;
    send_frame(8'h00, 1'b1, 3, 1'b0, bm);
    idle(20);
    chk("glitch_data", 32'(last_data), 0);
    chk("glitch_valid_cycles", 32'(valid_cycles - vc0), 1);

    // Framing error followed by a held-low line, then a good 0x81.
    vc0 = valid_cycles; fe0 = fe_count;
    send_frame(8'h3C, 1'b0, -1, 1'b0, bm);
    rx_in = 1'b0;
    repeat (40) @(negedge clk);
    idle(20);
    chk("ferr_pulses", 32'(fe_count - fe0), 1);
    chk("ferr_valid", 32'(valid_cycles - vc0), 0);
    vc0 = valid_cycles;
    send_frame(8'h81, 1'b1, -1, 1'b0, bm);
    idle(20);
    chk("after_ferr_data", 32'(last_data), 32'h81);
    chk("after_ferr_valid_cycles", 32'(valid_cycles - vc0), 1);
    chk("after_ferr_fe", 32'(fe_count - fe0), 1);

    // Overrun: two bytes with nobody accepting.
    rx_if.rx_ready = 1'b0;
    ov0 = ov_count;
    send_frame(8'h11, 1'b1, -1, 1'b0, bm);
    idle(10);
    send_frame(8'h22, 1'b1, -1, 1'b0, bm);
    idle(10);
    chk("ovr_data", 32'(rx_if.rx_data), 32'h11);
    chk("ovr_valid", 32'(rx_if.rx_valid), 1);
    chk("ovr_pulses", 32'(ov_count - ov0), 1);
    rx_if.rx_ready = 1'b1;
    @(negedge clk);
    chk("ovr_accept_clears", 32'(rx_if.rx_valid), 0);
    rx_if.rx_ready = 1'b0;
    idle(10);

    // Accept on exactly the delivery edge of the second byte.
    ov0 = ov_count;
    send_frame(8'h33, 1'b1, -1, 1'b0, bm);
    idle(10);
    chk("simul_first_data", 32'(rx_if.rx_data), 32'h33);
    send_frame(8'h44, 1'b1, -1, 1'b1, bm);
    chk("simul_data", 32'(rx_if.rx_data), 32'h44);
    chk("simul_valid", 32'(rx_if.rx_valid), 1);
    chk("simul_overrun", 32'(ov_count - ov0), 0);

    // Reset during data bit 4 of 0xF0, while a byte is still pending.
    rx_in = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx_in = 1'b0;
      repeat (CPB) @(negedge clk);
    end
    rx_in = 1'b1;
    repeat (CPB / 2) @(negedge clk);
    chk("mid_frame_busy", 32'(busy), 1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_valid", 32'(rx_if.rx_valid), 0);
    chk("rst_mid_data", 32'(rx_if.rx_data), 0);
    chk("rst_mid_busy", 32'(busy), 0);
    chk("rst_mid_frame_err", 32'(frame_err), 0);
    chk("rst_mid_overrun", 32'(overrun), 0);
    rx_in = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    rx_if.rx_ready = 1'b1;
    idle(20);
    vc0 = valid_cycles; fe0 = fe_count;
    send_frame(8'h5A, 1'b1, -1, 1'b0, bm);
    idle(20);
    chk("post_rst_data", 32'(last_data), 32'h5A);
    chk("post_rst_valid_cycles", 32'(valid_cycles - vc0), 1);
    chk("post_rst_fe", 32'(fe_count - fe0), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/uart_rx.md
# uart_rx

UART receiver for the TinyTapeout UART project: recovers 8N1 serial frames from the asynchronous `rx_in` pin and presents each byte on a valid/ready output port. It is the receive-side counterpart of the project's serial transmitter. It sits between a `ui_in` pin and the byte consumer in the top-level wrapper. Bit timing comes from a fixed clocks-per-bit divider, with majority-voted sampling at mid-bit.

## Interface

- `CLKS_PER_BIT`, default 87, system clocks per bit period (10 MHz / 115200 baud); legal range 8..4095.
- `clk`  input  1  system clock; all logic on its rising edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `rx_in`  input  1  asynchronous serial line; idle high.
- `rx_data`  output  8  received byte; stable while `rx_valid` is high.
- `rx_valid`  output  1  byte available; held high until accepted.
- `rx_ready`  input  1  consumer accepts `rx_data` on any cycle where `rx_valid && rx_ready`.
- `frame_err`  output  1  one-cycle pulse: stop bit sampled low.
- `overrun`  output  1  one-cycle pulse: a new byte completed while the previous one was unaccepted; the new byte is dropped.
- `busy`  output  1  high in every state except IDLE.

## Operation

- Input conditioning:
  - `rx_in` passes through a 2-flop synchronizer into `rx_s`; both flops reset to 1.
  - A 3-bit history of `rx_s` is kept; `bit_val` is the majority of the last three samples.
- Derived constant: H = CLKS_PER_BIT/2, integer division.
- The cycle counter is wide enough for CLKS_PER_BIT-1. It resets to 0 on every state entry and after every bit decision.
- States:
  - IDLE: on `rx_s == 0`, go to START with counter = 0.
  - START: at counter == H, evaluate `bit_val`.
    - `bit_val == 1`: false start; return to IDLE with no outputs.
    - `bit_val == 0`: go to DATA with bit index 0.
  - DATA: at counter == CLKS_PER_BIT-1, shift `bit_val` into the shift register (LSB first) and increment the bit index. After bit 7, go to STOP.
  - STOP: at counter == CLKS_PER_BIT-1, evaluate `bit_val`.
    - `bit_val == 1`: deliver the byte (see output rules), then go to IDLE.
    - `bit_val == 0`: pulse `frame_err`, discard the byte, go to BREAK.
  - BREAK: wait for `rx_s == 1`, then go to IDLE. This prevents a held-low line from being parsed as repeated 0x00 frames.
- Output rules at byte delivery:
  - `rx_valid == 0`, or `rx_valid && rx_ready` on the same cycle: load `rx_data`, set `rx_valid = 1`.
  - `rx_valid && !rx_ready`: keep the old `rx_data`, keep `rx_valid` high, pulse `overrun`.
- Handshake:
  - `rx_valid` clears on the cycle after `rx_valid && rx_ready`, unless a new byte loads on that same edge.
  - `rx_ready` while `rx_valid == 0` has no effect.
- Reset, asynchronous at any point including mid-frame: state IDLE, counter 0, shift register 0, `rx_data` = 0x00, `rx_valid` = 0, `frame_err` = 0, `overrun` = 0, `busy` = 0. A partially received frame is lost.

## Timing

- Synchronizer latency: 2 cycles from the first `clk` edge that samples `rx_in` low until `rx_s` is low (edge t0 = IDLE sees `rx_s == 0`).
- State and counter schedule, relative to t0:
  - START is entered at t0+1.
  - The start decision occurs at t0+1+H.
  - Data bit n is decided at t0+1+H+(n+1)·CLKS_PER_BIT.
  - The stop decision occurs at t0+1+H+9·CLKS_PER_BIT.
- `rx_valid`, `frame_err` and `overrun` are registered: they go high on the edge following the stop decision.
- Minimum recovery: after a good stop bit, IDLE accepts a new start on the next cycle. Back-to-back frames at the nominal rate are received without loss when `rx_ready` is held high.
- Baud tolerance: ±4% total mismatch at CLKS_PER_BIT ≥ 16.
- `busy` rises the cycle after t0 and falls the cycle after the return to IDLE.

## Test plan

- Nominal byte (CLKS_PER_BIT = 16, `rx_ready` = 1): send 0xA5 8N1 -> `rx_data` = 0xA5, `rx_valid` high exactly 1 cycle, `frame_err` = 0 and `overrun` = 0 throughout.
- False start and glitch rejection:
  - Pulse `rx_in` low for 4 cycles -> returns to IDLE, no `rx_valid`.
  - Apply a 1-cycle high glitch at the mid-point of a 0 data bit in 0x00 -> `rx_data` = 0x00.
- Framing error: send 0x3C with the stop bit low, then hold the line low 40 cycles, then high -> exactly one `frame_err` pulse, no `rx_valid`. The next 0x81 frame is received correctly.
- Overrun: `rx_ready` = 0, send 0x11 then 0x22 -> `rx_data` = 0x11 with `rx_valid` held high, one `overrun` pulse at the second stop decision. Raising `rx_ready` clears `rx_valid` on the next cycle.
- Simultaneous accept and new byte: assert `rx_ready` on exactly the delivery edge of the second of two frames -> `rx_data` = second byte, `rx_valid` stays high, no `overrun`.
- Reset mid-frame: assert `rst_n` low during data bit 4 of 0xF0 -> all outputs 0 immediately. After release, a clean 0x5A frame is received correctly.
